// File: rtl/vector_cache_pkg.sv
// Shared sizing and record types for the vector cache read-data-buffer path.
// The pending-entry record pairs an RDB slot with the ROB entry that owns it.
package vector_cache_pkg;

    localparam int RW_DB_ENTRY_NUM      = 8;
    localparam int DB_ENTRY_IDX_WIDTH   = 3;
    localparam int MSHR_ENTRY_IDX_WIDTH = 6;
    localparam int RDB_RD_LAT           = 2;
    localparam int US_CREDIT_NUM        = 4;

    typedef struct packed {
        logic [DB_ENTRY_IDX_WIDTH-1:0]   db_entry_id;
        logic [MSHR_ENTRY_IDX_WIDTH-1:0] rob_entry_id;
    } rdb_pend_t;

endpackage

// File: rtl/rdb_pend_fifo.sv
// In-order queue of filled RDB entries waiting for an upstream read slot.
// Head is presented combinationally; push and pop may occur in the same cycle.
module rdb_pend_fifo
    import vector_cache_pkg::*;
#(
    parameter int DEPTH = RW_DB_ENTRY_NUM,
    parameter int PTR_W = DB_ENTRY_IDX_WIDTH
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_push,
    input  rdb_pend_t      i_push_data,
    input  logic           i_pop,
    output rdb_pend_t      o_head,
    output logic           o_empty,
    output logic [PTR_W:0] o_count
);

    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    rdb_pend_t        r_mem [DEPTH];
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign o_empty = (r_count == '0);
    assign w_push  = i_push && (r_count != CNT_W'(DEPTH));
    assign w_pop   = i_pop && !o_empty;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
        end
    end

    // NOTE: storage has no reset; the pointers and count decide which slots hold live data.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/rdb_sched.sv
// RDB scheduler: entry allocation, fill writes with absolute priority, credit-limited
// in-order reads to upstream, and entry release / ROB completion on read return.
module rdb_sched
    import vector_cache_pkg::*;
#(
    parameter int ENTRY_NUM   = RW_DB_ENTRY_NUM,
    parameter int ENTRY_IDX_W = DB_ENTRY_IDX_WIDTH,
    parameter int ROB_IDX_W   = MSHR_ENTRY_IDX_WIDTH,
    parameter int RD_LAT      = RDB_RD_LAT,
    parameter int CREDIT_NUM  = US_CREDIT_NUM
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   alloc_vld,
    output logic [ENTRY_IDX_W-1:0] alloc_idx,
    input  logic                   alloc_rdy,
    input  logic                   fill_vld,
    input  logic [ENTRY_IDX_W-1:0] fill_entry_id,
    input  logic [ROB_IDX_W-1:0]   fill_rob_id,
    output logic                   rdb_mem_en,
    output logic                   rdb_wr_en,
    output logic [ENTRY_IDX_W-1:0] rdb_addr,
    output logic                   us_vld,
    output logic [ENTRY_IDX_W-1:0] us_entry_id,
    output logic [ROB_IDX_W-1:0]   us_rob_id,
    input  logic                   us_credit_rtn,
    output logic                   to_us_done,
    output logic [ROB_IDX_W-1:0]   to_us_done_idx,
    output logic [ENTRY_IDX_W:0]   pend_cnt,
    output logic                   err
);

    localparam int CR_W = $clog2(CREDIT_NUM + 1);

    logic [ENTRY_NUM-1:0]   r_free;
    logic [CR_W-1:0]        r_credit;
    logic                   r_err;
    logic [RD_LAT-1:0]      r_rd_vld;
    rdb_pend_t              r_rd_pld [RD_LAT];

    logic [ENTRY_NUM-1:0]   w_free_nxt;
    logic [ENTRY_IDX_W-1:0] w_alloc_idx;
    logic                   w_alloc_fire;
    logic                   w_fill_ok;
    logic                   w_fill_bad;
    logic                   w_issue;
    logic                   w_fifo_empty;
    logic                   w_credit_full;
    logic                   w_credit_bad;
    rdb_pend_t              w_head;
    rdb_pend_t              w_push_data;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_alloc_idx = '0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (r_free[i]) w_alloc_idx = ENTRY_IDX_W'(i);
        end
    end

    assign alloc_vld    = |r_free;
    assign alloc_idx    = w_alloc_idx;
    assign w_alloc_fire = alloc_vld && alloc_rdy;

    // A fill to a slot nobody owns still writes the SRAM but is never queued.
    assign w_fill_ok     = fill_vld && !r_free[fill_entry_id];
    assign w_fill_bad    = fill_vld && r_free[fill_entry_id];
    assign w_credit_full = (r_credit == CR_W'(CREDIT_NUM));
    assign w_credit_bad  = us_credit_rtn && w_credit_full;
    assign w_issue       = !fill_vld && !w_fifo_empty && (r_credit != '0);

    assign w_push_data.db_entry_id  = fill_entry_id;
    assign w_push_data.rob_entry_id = fill_rob_id;

    rdb_pend_fifo #(
        .DEPTH (ENTRY_NUM),
        .PTR_W (ENTRY_IDX_W)
    ) u_pend_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_fill_ok),
        .i_push_data (w_push_data),
        .i_pop       (w_issue),
        .o_head      (w_head),
        .o_empty     (w_fifo_empty),
        .o_count     (pend_cnt)
    );

    always_comb begin
        rdb_mem_en = 1'b0;
        rdb_wr_en  = 1'b0;
        rdb_addr   = '0;
        if (fill_vld) begin
            rdb_mem_en = 1'b1;
            rdb_wr_en  = 1'b1;
            rdb_addr   = fill_entry_id;
        end else if (w_issue) begin
            rdb_mem_en = 1'b1;
            rdb_addr   = w_head.db_entry_id;
        end
    end

    always_comb begin
        w_free_nxt = r_free;
        if (w_alloc_fire) w_free_nxt[w_alloc_idx] = 1'b0;
        if (us_vld)       w_free_nxt[us_entry_id] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_free   <= '1;
            r_credit <= CR_W'(CREDIT_NUM);
            r_err    <= 1'b0;
        end else begin
            r_free <= w_free_nxt;
            if (w_issue && !us_credit_rtn) begin
                r_credit <= r_credit - CR_W'(1);
            end else if (!w_issue && us_credit_rtn && !w_credit_full) begin
                r_credit <= r_credit + CR_W'(1);
            end
            if (w_fill_bad || w_credit_bad) r_err <= 1'b1;
        end
    end

    // Fixed-latency shadow of the SRAM read; payload is zeroed on idle slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) r_rd_pld[i] <= '0;
        end else begin
            r_rd_vld[0] <= w_issue;
            r_rd_pld[0] <= w_issue ? w_head : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                r_rd_vld[i] <= r_rd_vld[i-1];
                r_rd_pld[i] <= r_rd_pld[i-1];
            end
        end
    end

    assign us_vld         = r_rd_vld[RD_LAT-1];
    assign us_entry_id    = r_rd_pld[RD_LAT-1].db_entry_id;
    assign us_rob_id      = r_rd_pld[RD_LAT-1].rob_entry_id;
    assign to_us_done     = us_vld;
    assign to_us_done_idx = us_rob_id;
    assign err            = r_err;

endmodule

// File: tb/tb_rdb_sched.sv
// Randomised and directed bench for rdb_sched with a queue-based reference model and
// a scoreboard monitor that compares SRAM port, allocation, pending count and returns.
module tb_rdb_sched;
    import vector_cache_pkg::*;

    localparam int EN         = 8;
    localparam int IW         = 3;
    localparam int RW         = 6;
    localparam int RD_LAT     = 2;
    localparam int CREDIT_NUM = 4;

    logic          clk;
    logic          rst_n;
    logic          alloc_vld;
    logic [IW-1:0] alloc_idx;
    logic          alloc_rdy;
    logic          fill_vld;
    logic [IW-1:0] fill_entry_id;
    logic [RW-1:0] fill_rob_id;
    logic          rdb_mem_en;
    logic          rdb_wr_en;
    logic [IW-1:0] rdb_addr;
    logic          us_vld;
    logic [IW-1:0] us_entry_id;
    logic [RW-1:0] us_rob_id;
    logic          us_credit_rtn;
    logic          to_us_done;
    logic [RW-1:0] to_us_done_idx;
    logic [IW:0]   pend_cnt;
    logic          err;

    rdb_sched #(
        .ENTRY_NUM   (EN),
        .ENTRY_IDX_W (IW),
        .ROB_IDX_W   (RW),
        .RD_LAT      (RD_LAT),
        .CREDIT_NUM  (CREDIT_NUM)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alloc_vld      (alloc_vld),
        .alloc_idx      (alloc_idx),
        .alloc_rdy      (alloc_rdy),
        .fill_vld       (fill_vld),
        .fill_entry_id  (fill_entry_id),
        .fill_rob_id    (fill_rob_id),
        .rdb_mem_en     (rdb_mem_en),
        .rdb_wr_en      (rdb_wr_en),
        .rdb_addr       (rdb_addr),
        .us_vld         (us_vld),
        .us_entry_id    (us_entry_id),
        .us_rob_id      (us_rob_id),
        .us_credit_rtn  (us_credit_rtn),
        .to_us_done     (to_us_done),
        .to_us_done_idx (to_us_done_idx),
        .pend_cnt       (pend_cnt),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int entry;
        int rob;
        int due;
    } rd_t;

    bit  m_free  [EN];
    bit  m_owned [EN];
    rd_t m_pend  [$];
    rd_t m_exp_q [$];
    rd_t m_ret_q [$];
    int  m_credit;
    bit  m_err;

    function automatic int m_lowest_free();
        for (int i = 0; i < EN; i++) if (m_free[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < EN; i++) begin
            m_free[i]  = 1'b1;
            m_owned[i] = 1'b0;
        end
        m_pend.delete();
        m_exp_q.delete();
        m_ret_q.delete();
        m_credit = CREDIT_NUM;
        m_err    = 1'b0;
    endtask

    task automatic model_step();
        bit  issue;
        bit  full;
        int  lf;
        rd_t rd;
        if (!rst_n) begin
            model_reset();
            return;
        end
        issue = !fill_vld && (m_pend.size() > 0) && (m_credit > 0);
        full  = (m_credit == CREDIT_NUM);
        lf    = m_lowest_free();
        if (fill_vld) begin
            if (m_free[fill_entry_id]) begin
                m_err = 1'b1;
            end else begin
                rd.entry = int'(fill_entry_id);
                rd.rob   = int'(fill_rob_id);
                rd.due   = 0;
                m_pend.push_back(rd);
                m_owned[fill_entry_id] = 1'b0;
            end
        end
        if (issue) begin
            rd     = m_pend.pop_front();
            rd.due = cyc + RD_LAT;
            m_exp_q.push_back(rd);
            m_ret_q.push_back(rd);
        end
        if (m_ret_q.size() > 0 && m_ret_q[0].due == cyc) begin
            m_free[m_ret_q[0].entry] = 1'b1;
            void'(m_ret_q.pop_front());
        end
        if (alloc_rdy && lf >= 0) begin
            m_free[lf]  = 1'b0;
            m_owned[lf] = 1'b1;
        end
        if (us_credit_rtn && full) m_err = 1'b1;
        if (issue && !us_credit_rtn)              m_credit--;
        else if (!issue && us_credit_rtn && !full) m_credit++;
        cyc++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            model_step();
        end
    end

    // ---------------- scoreboard monitor ----------------
    task automatic monitor_step();
        bit exp_issue;
        bit exp_us;
        int exp_addr;
        int lf;
        exp_issue = !fill_vld && (m_pend.size() > 0) && (m_credit > 0);
        exp_addr  = 0;
        if (fill_vld)       exp_addr = int'(fill_entry_id);
        else if (exp_issue) exp_addr = m_pend[0].entry;
        check("rdb_mem_en", rdb_mem_en, fill_vld || exp_issue);
        check("rdb_wr_en", rdb_wr_en, fill_vld);
        check("rdb_addr", rdb_addr, exp_addr);
        lf = m_lowest_free();
        check("alloc_vld", alloc_vld, lf >= 0);
        check("alloc_idx", alloc_idx, (lf >= 0) ? lf : 0);
        check("pend_cnt", pend_cnt, m_pend.size());
        check("err", err, m_err);
        while (m_exp_q.size() > 0 && m_exp_q[0].due < cyc) void'(m_exp_q.pop_front());
        exp_us = (m_exp_q.size() > 0) && (m_exp_q[0].due == cyc);
        check("us_vld", us_vld, exp_us);
        check("to_us_done", to_us_done, exp_us);
        if (exp_us) begin
            check("us_entry_id", us_entry_id, m_exp_q[0].entry);
            check("us_rob_id", us_rob_id, m_exp_q[0].rob);
            check("to_us_done_idx", to_us_done_idx, m_exp_q[0].rob);
            void'(m_exp_q.pop_front());
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) monitor_step();
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int e, input int r);
        fill_vld      = 1'b1;
        fill_entry_id = IW'(e);
        fill_rob_id   = RW'(r);
        step();
        fill_vld = 1'b0;
    endtask

    task automatic alloc_n(input int n);
        alloc_rdy = 1'b1;
        repeat (n) step();
        alloc_rdy = 1'b0;
    endtask

    // Return credits and let the pipe drain until the model is idle; bounded.
    task automatic settle();
        for (int k = 0; k < 300; k++) begin
            if (m_pend.size() == 0 && m_exp_q.size() == 0 && m_credit == CREDIT_NUM) break;
            us_credit_rtn = (m_credit < CREDIT_NUM);
            step();
        end
        us_credit_rtn = 1'b0;
        @(negedge clk);
        check("settle_pend_cnt", pend_cnt, 0);
        check("settle_us_vld", us_vld, 0);
        step();
    endtask

    initial begin
        int cand[$];
        rst_n         = 1'b0;
        alloc_rdy     = 1'b0;
        fill_vld      = 1'b0;
        fill_entry_id = '0;
        fill_rob_id   = '0;
        us_credit_rtn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_alloc_vld", alloc_vld, 1);
        check("rst_alloc_idx", alloc_idx, 0);
        check("rst_pend_cnt", pend_cnt, 0);
        check("rst_us_vld", us_vld, 0);
        check("rst_to_us_done", to_us_done, 0);
        check("rst_err", err, 0);
        check("rst_mem_en", rdb_mem_en, 0);
        check("rst_addr", rdb_addr, 0);
        check("rst_us_ids", {us_entry_id, us_rob_id, to_us_done_idx}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Allocate all entries in index order, then the pool is empty.
        alloc_n(8);
        @(negedge clk);
        check("pool_empty", alloc_vld, 0);
        step();

        // Single fill: read next cycle, return two later, slot offered again after.
        fill(3, 'h15);
        step();
        step();
        @(negedge clk);
        check("t0p3_us_vld", us_vld, 1);
        check("t0p3_done_idx", to_us_done_idx, 'h15);
        step();
        @(negedge clk);
        check("t0p4_alloc_idx", alloc_idx, 3);
        step();

        // Back-to-back fills starve reads; queue depth peaks at four.
        alloc_n(1);
        settle();
        for (int i = 0; i < 4; i++) fill(i, 'h20 + i);
        @(negedge clk);
        check("pend_peak", pend_cnt, 4);
        step();
        settle();

        // Six fills against four credits; one return releases one more read.
        alloc_n(2);
        fill(4, 'h30); fill(5, 'h31); fill(6, 'h32); fill(7, 'h33); fill(0, 'h34); fill(1, 'h35);
        repeat (8) step();
        @(negedge clk);
        check("credit_block_pend", pend_cnt, 2);
        step();
        us_credit_rtn = 1'b1;
        step();
        us_credit_rtn = 1'b0;
        repeat (4) step();
        @(negedge clk);
        check("one_rtn_pend", pend_cnt, 1);
        step();
        settle();

        // Bad fill to a free slot, then a return at full credit; err is sticky.
        fill(5, 'h2a);
        @(negedge clk);
        check("bad_fill_err", err, 1);
        check("bad_fill_pend", pend_cnt, 0);
        step();
        us_credit_rtn = 1'b1;
        step();
        us_credit_rtn = 1'b0;
        alloc_n(5);
        for (int i = 0; i < 5; i++) fill(i, 'h10 + i);
        repeat (8) step();
        @(negedge clk);
        check("saturated_pend", pend_cnt, 1);
        check("err_sticky", err, 1);
        step();
        settle();

        // Reset with two reads in flight: neither may ever return.
        alloc_n(2);
        fill(0, 'h01);
        fill(1, 'h02);
        step();
        @(negedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_alloc_idx", alloc_idx, 0);
        check("post_rst_pend", pend_cnt, 0);
        check("post_rst_err", err, 0);
        check("post_rst_us_vld", us_vld, 0);
        step();
        alloc_n(5);
        for (int i = 0; i < 5; i++) fill(i, 'h3a + i);
        repeat (8) step();
        @(negedge clk);
        check("post_rst_credit", pend_cnt, 1);
        step();
        settle();

        // Randomised traffic with legal fills and returns.
        for (int n = 0; n < 2500; n++) begin
            cand.delete();
            for (int i = 0; i < EN; i++) if (m_owned[i]) cand.push_back(i);
            alloc_rdy = 1'($urandom_range(0, 1));
            if (cand.size() > 0 && $urandom_range(0, 2) != 0) begin
                fill_vld      = 1'b1;
                fill_entry_id = IW'(cand[$urandom_range(0, cand.size() - 1)]);
                fill_rob_id   = RW'($urandom_range(0, 63));
            end else begin
                fill_vld = 1'b0;
            end
            us_credit_rtn = (m_credit < CREDIT_NUM) && ($urandom_range(0, 1) == 1);
            step();
        end
        alloc_rdy = 1'b0;
        fill_vld  = 1'b0;
        settle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time %0t reached, want finish before it", $time);
        $fatal(1, "watchdog");
    end

endmodule
